// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_B    = 2'd2
  } grant_t;

  localparam logic [3:0]  WB_READ   = 4'b0000;
  localparam int unsigned NUM_LANES = 4;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; a tie goes to the port not granted last.
module rr_arbiter2
  import memory_arbiter_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic i_req_a,
  input  logic i_req_b,
  output logic o_gnt_a,
  output logic o_gnt_b
);

  grant_t r_last_grant;
  grant_t w_grant;

  always_comb begin
    w_grant = GNT_NONE;
    if (i_req_a && i_req_b) begin
      w_grant = (r_last_grant == GNT_A) ? GNT_B : GNT_A;
    end else if (i_req_a) begin
      w_grant = GNT_A;
    end else if (i_req_b) begin
      w_grant = GNT_B;
    end
  end

  assign o_gnt_a = (w_grant == GNT_A);
  assign o_gnt_b = (w_grant == GNT_B);

  // Reset to B so that A wins the first tie.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_last_grant <= GNT_B;
    end else if (w_grant != GNT_NONE) begin
      r_last_grant <= w_grant;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Merges instruction-fetch port A and load/store port B onto one RAM port,
// tagging reads so data returns to the right port one cycle later.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned MEMORY_BUS_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH       = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        a_req,
  input  logic [ADDR_WIDTH-1:0]       a_addr,
  output logic                        a_ready,
  output logic                        a_rvalid,
  output logic [MEMORY_BUS_WIDTH-1:0] a_rdata,
  input  logic                        b_req,
  input  logic [NUM_LANES-1:0]        b_wb,
  input  logic [ADDR_WIDTH-1:0]       b_addr,
  input  logic [MEMORY_BUS_WIDTH-1:0] b_wdata,
  output logic                        b_ready,
  output logic                        b_rvalid,
  output logic [MEMORY_BUS_WIDTH-1:0] b_rdata,
  output logic                        mem_enable,
  output logic [NUM_LANES-1:0]        mem_wb,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [MEMORY_BUS_WIDTH-1:0] mem_wdata,
  input  logic [MEMORY_BUS_WIDTH-1:0] mem_rdata
);

  logic                        w_gnt_a;
  logic                        w_gnt_b;
  logic                        w_a_rvalid;
  logic                        w_b_rvalid;
  logic                        r_rd_pending;
  grant_t                      r_rd_owner;
  logic [MEMORY_BUS_WIDTH-1:0] r_a_rdata;
  logic [MEMORY_BUS_WIDTH-1:0] r_b_rdata;

  // Requests are masked while reset is held so no grant leaks out during reset.
  rr_arbiter2 u_rr_arbiter2 (
    .clock   (clock),
    .reset   (reset),
    .i_req_a (a_req & reset),
    .i_req_b (b_req & reset),
    .o_gnt_a (w_gnt_a),
    .o_gnt_b (w_gnt_b)
  );

  always_comb begin
    a_ready    = w_gnt_a;
    b_ready    = w_gnt_b;
    mem_enable = w_gnt_a | w_gnt_b;
    mem_wb     = WB_READ;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (w_gnt_a) begin
      mem_addr = a_addr;
    end else if (w_gnt_b) begin
      mem_wb    = b_wb;
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
    end
  end

  assign w_a_rvalid = r_rd_pending && (r_rd_owner == GNT_A);
  assign w_b_rvalid = r_rd_pending && (r_rd_owner == GNT_B);
  assign a_rvalid   = w_a_rvalid;
  assign b_rvalid   = w_b_rvalid;

  // RAM data is live during the rvalid cycle; the register holds it afterwards.
  assign a_rdata = w_a_rvalid ? mem_rdata : r_a_rdata;
  assign b_rdata = w_b_rvalid ? mem_rdata : r_b_rdata;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_pending <= 1'b0;
      r_rd_owner   <= GNT_NONE;
      r_a_rdata    <= '0;
      r_b_rdata    <= '0;
    end else begin
      r_rd_pending <= w_gnt_a | (w_gnt_b && (b_wb == WB_READ));
      if (w_gnt_a) begin
        r_rd_owner <= GNT_A;
      end else if (w_gnt_b) begin
        r_rd_owner <= GNT_B;
      end
      if (w_a_rvalid) begin
        r_a_rdata <= mem_rdata;
      end
      if (w_b_rvalid) begin
        r_b_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-port arbiter sitting directly upstream of the single-port boot/program RAM. Merges the instruction-fetch port (A, read-only) and the load/store port (B, byte-masked read/write) onto the RAM's single `interface_memory` port, one access per cycle, with round-robin priority on conflict. Tags each read with its owner and returns RAM data to the right port with fixed one-cycle latency.

## Interface
Parameters:
- `MEMORY_BUS_WIDTH`, 32: data width; fixed at 32 (four byte lanes).
- `ADDR_WIDTH`, 32: address width passed through to the RAM.

Ports:
- `clock`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `a_req`  in  1  port A read request.
- `a_addr`  in  ADDR_WIDTH  port A byte address.
- `a_ready`  out  1  port A request accepted this cycle.
- `a_rvalid`  out  1  port A read data valid.
- `a_rdata`  out  32  port A read data.
- `b_req`  in  1  port B request.
- `b_wb`  in  4  byte write mask; bit0 = lane [31:24] at addr+0 … bit3 = lane [7:0] at addr+3; 0 = read.
- `b_addr`  in  ADDR_WIDTH  port B byte address.
- `b_wdata`  in  32  port B write data.
- `b_ready`  out  1  port B request accepted this cycle.
- `b_rvalid`  out  1  port B read data valid (reads only).
- `b_rdata`  out  32  port B read data.
- `mem_enable`  out  1  to RAM `enable_in`.
- `mem_wb`  out  4  to RAM `wb_in`.
- `mem_addr`  out  ADDR_WIDTH  to RAM `addr_in`.
- `mem_wdata`  out  32  to RAM `data_in`.
- `mem_rdata`  in  32  from RAM `data_out`.

## Operation
- Grant per cycle: only A → A; only B → B; both → port not granted last (`last_grant` register); neither → none.
- Granted port: `x_ready`=1 combinationally that cycle; RAM side driven combinationally from its request. A: `mem_enable`=1, `mem_wb`=0. B: `mem_enable`=1, `mem_wb`=`b_wb`, `mem_wdata`=`b_wdata`.
- No grant: `mem_enable`=0, `mem_wb`=0, `mem_addr`=0, `mem_wdata`=0.
- Requests are level; a requester holds address/data until it sees `ready`. Ungranted port's `ready`=0.
- Read tag: on granted read (A, or B with `b_wb`=0) register `rd_pending`=1, `rd_owner`=port. Next cycle raise owner's `rvalid` for exactly one cycle and capture `mem_rdata` into that port's `rdata` register.
- `x_rdata` holds last captured value until the next read for that port completes.
- B writes produce no `rvalid`.
- `last_grant` updates only when a grant occurs.
- No address checking, alignment enforcement, or backpressure on `rvalid`; requester must accept data in the `rvalid` cycle.

## Timing
- Reset (async assert, sync-safe release): `a_ready`, `b_ready`, `a_rvalid`, `b_rvalid`, `mem_enable`=0; `mem_wb`, `mem_addr`, `mem_wdata`, `a_rdata`, `b_rdata`=0; `rd_pending`=0; `last_grant`=B (A wins the first tie).
- Accept latency 0 (same-cycle `ready`); read latency 1 cycle (`rvalid` the cycle after `ready`).
- Throughput: one access per cycle; back-to-back reads from alternating or same ports all return in order.
- Write then read same address on consecutive grants: read returns new data (RAM writes at grant edge, read samples on following edge).
- Simultaneous read and write to same address: impossible (one grant per cycle).
- Both requesting continuously: strict alternation A,B,A,B…
- Reset mid-read: pending `rvalid` dropped; no `rvalid` after release.

## Structure
- `memory_arbiter_pkg`: `grant_t` enum {`GNT_NONE`, `GNT_A`, `GNT_B`}, `WB_READ` = 4'b0000, lane count constant.
- Sub-module `rr_arbiter2`: two requests in, one-hot grant out, owns `last_grant`. Datapath muxing and read tagging stay in `memory_arbiter`.

## Test plan
- Reset release, no requests → all outputs 0 for 5 cycles, `mem_enable`=0.
- A alone reads 0x100, RAM word 0xDEADBEEF → `a_ready` cycle 0, `a_rvalid`=1 and `a_rdata`=0xDEADBEEF cycle 1, `a_rvalid`=0 cycle 2.
- A and B both held for 4 cycles (A read 0x0, B read 0x4) → grants A,B,A,B; `rvalid` alternates A,B,A,B one cycle later.
- B writes 0x11223344 mask 4'b1111 to 0x20, then B reads 0x20 next cycle → `b_rvalid`=1, `b_rdata`=0x11223344; partial write mask 4'b0001 with 0xAA000000 → read 0xAA223344.
- B write only → `mem_wb`=`b_wb`, no `b_rvalid` ever asserted.
- A read granted, `reset` asserted before next edge → `a_rvalid` stays 0 through and after release; `a_rdata`=0.
